// File: rtl/c17_response_checker_if.sv
// Bus bundle between a c17 stimulus/response observer and its checker.
// Host side uses the master modport and the checker uses the slave modport.
interface c17_response_checker_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             start;
  logic [4:0]       stim_in;
  logic [1:0]       resp_in;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_vec;
  logic [15:0]      signature;

  modport master (
    output en, start, stim_in, resp_in,
    input  busy, done, error, err_count, first_err_vec, signature
  );

  modport slave (
    input  en, start, stim_in, resp_in,
    output busy, done, error, err_count, first_err_vec, signature
  );
endinterface

// File: rtl/c17_response_checker.sv
// Response checker for the registered c17 benchmark: golden model + delay line, compare, MISR.
// Optional macro C17_RESPONSE_CHECKER_HALT_ON_ERROR_EN stops the run at the first mismatch.
module c17_response_checker #(
  parameter int LATENCY     = 2,
  parameter int NUM_VECTORS = 8192,
  parameter int CNT_W       = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  c17_response_checker_if.slave bus
);

  localparam int VEC_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int WARM_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [1:0] c17_golden(input logic [4:0] s);
    logic g10, g11, g16, g19;
    g10 = ~(s[4] & s[2]);
    g11 = ~(s[2] & s[1]);
    g16 = ~(s[3] & g11);
    g19 = ~(g11 & s[0]);
    return {~(g10 & g16), ~(g16 & g19)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [1:0] din);
    return {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {14'b0, din};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic [1:0]         dly_r [LATENCY];
  logic [1:0]         tap_s;
  logic               mismatch_s;
  logic               compare_s;
  logic               launch_s;
  logic               vec_last_s;
  logic               warm_last_s;
  logic [VEC_W-1:0]   vec_cnt_r;
  logic [WARM_W-1:0]  warm_cnt_r;
  logic               error_r;
  logic [CNT_W-1:0]   err_count_r;
  logic [CNT_W-1:0]   first_err_r;
  logic [15:0]        sig_r;

  assign tap_s       = dly_r[LATENCY-1];
  assign mismatch_s  = (tap_s != bus.resp_in);
  assign vec_last_s  = (vec_cnt_r == VEC_W'(NUM_VECTORS - 1));
  assign warm_last_s = (warm_cnt_r == WARM_W'(LATENCY - 1));

  // Qualifiers for starting a run and for making a compare on this edge
  always_comb begin
    launch_s  = 1'b0;
    compare_s = 1'b0;
    if (bus.en) begin
      launch_s  = bus.start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
      compare_s = (state_r == ST_CHECK);
    end else begin
      launch_s  = 1'b0;
      compare_s = 1'b0;
    end
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic; every transition is gated by en
  always_comb begin
    state_nxt_s = state_r;
    if (!bus.en) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = bus.start ? ST_WARMUP : ST_IDLE;
        ST_WARMUP: state_nxt_s = warm_last_s ? ST_CHECK : ST_WARMUP;
        ST_CHECK: begin
          if (vec_last_s) begin
            state_nxt_s = ST_DONE;
`ifdef C17_RESPONSE_CHECKER_HALT_ON_ERROR_EN
          end else if (mismatch_s) begin
            state_nxt_s = ST_DONE;
`endif
          end else begin
            state_nxt_s = ST_CHECK;
          end
        end
        ST_DONE:   state_nxt_s = bus.start ? ST_WARMUP : ST_DONE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state, captured by the state register
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_WARMUP: busy_nxt_s = 1'b1;
      ST_CHECK:  busy_nxt_s = 1'b1;
      ST_DONE:   done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Golden delay line, shifted on every enabled edge regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) dly_r[i] <= 2'b00;
    end else if (bus.en) begin
      dly_r[0] <= c17_golden(bus.stim_in);
      for (int i = 1; i < LATENCY; i++) dly_r[i] <= dly_r[i-1];
    end
  end

  // Run counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_r   <= '0;
      warm_cnt_r  <= '0;
      error_r     <= 1'b0;
      err_count_r <= '0;
      first_err_r <= {CNT_W{1'b1}};
      sig_r       <= 16'h0000;
    end else if (launch_s) begin
      vec_cnt_r   <= '0;
      warm_cnt_r  <= '0;
      error_r     <= 1'b0;
      err_count_r <= '0;
      first_err_r <= {CNT_W{1'b1}};
      sig_r       <= 16'h0000;
    end else if (compare_s) begin
      vec_cnt_r <= vec_cnt_r + VEC_W'(1);
      sig_r     <= misr_step(sig_r, bus.resp_in);
      if (mismatch_s) begin
        error_r <= 1'b1;
        if (err_count_r != {CNT_W{1'b1}}) err_count_r <= err_count_r + CNT_W'(1);
        if (first_err_r == {CNT_W{1'b1}}) first_err_r <= CNT_W'(vec_cnt_r);
      end
    end else if (bus.en && (state_r == ST_WARMUP)) begin
      warm_cnt_r <= warm_cnt_r + WARM_W'(1);
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.error         = error_r;
  assign bus.err_count     = err_count_r;
  assign bus.first_err_vec = first_err_r;
  assign bus.signature     = sig_r;

endmodule

// File: tb/tb_c17_response_checker.sv
// Randomized self-checking bench for c17_response_checker against a vector-level reference model.
module tb_c17_response_checker;

  localparam int LAT = 2;
  localparam int NV  = 64;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [4:0] stim_v [NV];
  logic [1:0] resp_v [NV];

  c17_response_checker_if #(.CNT_W(16)) bus ();

  c17_response_checker #(
    .LATENCY    (LAT),
    .NUM_VECTORS(NV),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // c17 outputs in sum-of-products form
  function automatic logic [1:0] gold(input logic [4:0] s);
    logic n1, n2, n3, n6, n7;
    {n1, n2, n3, n6, n7} = s;
    return {(n1 & n3) | (n2 & ~(n3 & n6)), ~(n3 & n6) & (n2 | n7)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_done"},  32'(bus.done), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
    chk({tag, "_cnt"},   32'(bus.err_count), 32'd0);
    chk({tag, "_first"}, 32'(bus.first_err_vec), 32'hFFFF);
    chk({tag, "_sig"},   32'(bus.signature), 32'd0);
  endtask

  // Run the vectors in stim_v/resp_v and compare final results with the model
  task automatic run_and_check(input string tag, input bit do_stall);
    int         err_m;
    int         first_m;
    int         last_m;
    int         stall_at;
    logic [15:0] sig_m;
    logic [15:0] sig_hold;
    bit         halted;

    err_m = 0; first_m = -1; last_m = NV - 1; sig_m = 16'h0000; halted = 1'b0;
    for (int i = 0; i < NV && !halted; i++) begin
      sig_m = {sig_m[14:0], 1'b0} ^ (sig_m[15] ? 16'h1021 : 16'h0000) ^ {14'b0, resp_v[i]};
      if (resp_v[i] != gold(stim_v[i])) begin
        err_m++;
        if (first_m < 0) first_m = i;
`ifdef C17_RESPONSE_CHECKER_HALT_ON_ERROR_EN
        halted = 1'b1;
        last_m = i;
`endif
      end
    end

    stall_at = $urandom_range(LAT + NV - 1, LAT + 2);
    bus.en = 1'b1;
    bus.start = 1'b1;
    bus.stim_in = 5'($urandom_range(31, 0));
    bus.resp_in = 2'($urandom_range(3, 0));
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);

    for (int c = 1; c <= LAT + NV; c++) begin
      if (do_stall && c == stall_at) begin
        sig_hold = bus.signature;
        bus.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
          bus.start   = 1'b1;
          bus.stim_in = 5'($urandom_range(31, 0));
          bus.resp_in = 2'($urandom_range(3, 0));
          tick();
        end
        chk({tag, "_stall_sig"}, 32'(bus.signature), 32'(sig_hold));
        chk({tag, "_stall_busy"}, 32'(bus.busy), 32'((c - 1) < (LAT + 1 + last_m)));
        bus.en = 1'b1;
        bus.start = 1'b0;
      end
      bus.start   = (c == 2);
      bus.stim_in = (c - 1 < NV) ? stim_v[c-1] : 5'($urandom_range(31, 0));
      bus.resp_in = (c - 1 - LAT >= 0 && c - 1 - LAT < NV) ? resp_v[c-1-LAT]
                                                           : 2'($urandom_range(3, 0));
      tick();
    end
    bus.start = 1'b0;

    chk({tag, "_done"},  32'(bus.done), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'(err_m != 0));
    chk({tag, "_cnt"},   32'(bus.err_count), 32'(err_m));
    chk({tag, "_first"}, 32'(bus.first_err_vec), (first_m < 0) ? 32'hFFFF : 32'(first_m));
    chk({tag, "_sig"},   32'(bus.signature), 32'(sig_m));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.start = 1'b0;
    bus.stim_in = 5'b00000;
    bus.resp_in = 2'b00;
    repeat (3) tick();
    rst_n = 1'b1;
    bus.en = 1'b1;
    repeat (20) tick();
    check_reset_values("reset");

    // start while en is low must not be latched
    bus.en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.en = 1'b1;
    tick();
    chk("start_en_low_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < NV; i++) begin stim_v[i] = 5'b00000; resp_v[i] = 2'b00; end
    run_and_check("zeros", 1'b0);

    for (int i = 0; i < NV; i++) begin stim_v[i] = 5'b11111; resp_v[i] = (i == 5) ? 2'b11 : 2'b10; end
    run_and_check("ones_err5", 1'b0);

    for (int i = 0; i < NV; i++) begin stim_v[i] = 5'(i); resp_v[i] = 2'b00; end
    run_and_check("toggle_stuck00", 1'b0);

    for (int i = 0; i < NV; i++) begin
      stim_v[i] = 5'($urandom_range(31, 0));
      resp_v[i] = gold(stim_v[i]);
    end
    run_and_check("golden_stall", 1'b1);

    for (int i = 0; i < NV; i++) begin
      stim_v[i] = 5'($urandom_range(31, 0));
      resp_v[i] = gold(stim_v[i]) ^ (($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00);
    end
    run_and_check("rand_faults", 1'b0);

    for (int i = 0; i < NV; i++) begin
      stim_v[i] = 5'($urandom_range(31, 0));
      resp_v[i] = gold(stim_v[i]) ^ ((i == 3) ? 2'b01 : 2'b00);
    end
    run_and_check("inject3", 1'b0);

    // Reset pulse in the middle of a faulty run
    bus.en = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < LAT + 8; c++) begin
      bus.stim_in = 5'b11111;
      bus.resp_in = 2'b01;
      tick();
    end
    chk("midrun_error_set", 32'(bus.error), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    #2;
    rst_n = 1'b1;
    tick();
    check_reset_values("after_reset");

    for (int i = 0; i < NV; i++) begin
      stim_v[i] = 5'($urandom_range(31, 0));
      resp_v[i] = gold(stim_v[i]);
    end
    run_and_check("post_reset_golden", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c17_response_checker.md
Name: c17_response_checker

Overview:
- On-chip response checker for the registered c17 benchmark.
- Observes the stimulus driven into c17 (N1,N2,N3,N6,N7) and the responses it returns (N22,N23).
- Recomputes golden responses with an internal c17 model delayed to match DUT latency, then compares them against the observed responses.
- Reports sticky error, mismatch count, first failing vector index and a 16-bit MISR signature of the observed responses; sits beside the c17 instance in fault-injection / golden-vs-faulty runs.

Parameters:
- LATENCY, 2, DUT stimulus-to-response delay in en-qualified clk edges (input DFF + output DFF); legal 1..8.
- NUM_VECTORS, 8192, number of compared vectors per run.
- CNT_W, 16, width of err_count and first_err_vec.

Ports:
- clk  input  1  system clock, posedge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  cycle enable; when low, all state holds.
- start  input  1  single-cycle pulse; begins a run from IDLE or DONE.
- stim_in  input  5  {N1,N2,N3,N6,N7}, bit4=N1, as presented to the DUT.
- resp_in  input  2  {N22,N23}, bit1=N22, DUT outputs.
- busy  output  1  high in WARMUP or CHECK.
- done  output  1  high in DONE.
- error  output  1  sticky; any mismatch this run.
- err_count  output  CNT_W  mismatches this run, saturating at all-ones.
- first_err_vec  output  CNT_W  vector index (0-based) of first mismatch; all-ones if none.
- signature  output  16  MISR over resp_in during CHECK.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, error=0, err_count=0, first_err_vec=all-ones, signature=0x0000; golden delay line cleared to 0.
- Golden model (combinational on stim_in s1,s2,s3,s6,s7):
  - g10=~(s1&s3), g11=~(s3&s6), g16=~(s2&g11), g19=~(g11&s7)
  - exp22=~(g10&g16), exp23=~(g16&g19)
- Delay line: LATENCY registers shift {exp22,exp23} on every clk edge with en=1. The tap at depth LATENCY is compared with resp_in at the same edge.
- FSM (advances only on edges with en=1):
  - IDLE: start -> WARMUP. On entry, clear error, err_count, first_err_vec=all-ones, signature=0, vec counter=0, warm counter=0. The delay line is not cleared.
  - WARMUP: count LATENCY edges; no compares; after the LATENCY-th edge -> CHECK.
  - CHECK: each edge compares tap vs resp_in.
    - On mismatch: error<=1; err_count+=1 (saturating); if first_err_vec is all-ones, capture vec counter.
    - signature <= {signature[14:0],0} ^ (signature[15] ? 0x1021 : 0) ^ {14'b0,resp_in}.
    - vec counter+=1; when it reaches NUM_VECTORS-1 on a compare edge -> DONE.
  - DONE: results hold; start -> WARMUP with the same clears as from IDLE.
- start while busy: ignored. start with en=0: ignored (not latched).
- en=0 for any duration: FSM, counters, delay line and signature hold; no compare is made.
- Reset mid-run: immediate return to reset values; no partial results retained.
- err_count at all-ones: stays all-ones; error stays 1.

Optional Feature:
- Macro: C17_RESPONSE_CHECKER_HALT_ON_ERROR_EN.
- Defined: the first mismatch in CHECK moves the FSM to DONE on the same edge (error, err_count=1, first_err_vec captured, signature includes the failing vector). Remaining vectors are not checked.
- Undefined: the run always completes NUM_VECTORS compares.

Test Plan:
- Reset release, no start, 20 edges -> busy=0, done=0, error=0, err_count=0, first_err_vec=0xFFFF, signature=0x0000.
- Golden DUT, stim_in=5'b00000 constant, resp_in=2'b00; start, then LATENCY+NUM_VECTORS edges -> done=1, error=0, err_count=0, signature=0x0000.
- stim_in=5'b11111 constant, resp_in forced to 2'b10 (correct) except 2'b11 at vector index 5 -> error=1, err_count=1, first_err_vec=5.
- Toggling stimulus as in the golden c17 bench, with resp_in stuck at 2'b00 -> err_count equals the count of vectors where expected≠00; first_err_vec equals the index of the first such vector.
- en held low for 10 edges mid-CHECK with a golden DUT -> vec counter and signature unchanged across the stall; final error=0.
- rst_n pulsed low mid-CHECK -> all outputs return to reset values asynchronously.
- With HALT macro defined, inject a mismatch at vector 3 -> done=1 at that edge, err_count=1, first_err_vec=3.
